// File: rtl/sa_cache_miss_ctrl.sv
// Miss sequencer between a CPU load/store port, a 4-way set-associative cache and a
// line-granular memory port: lookup, optional victim writeback, line fill, replay.
`timescale 1ns / 1ps

module sa_cache_miss_ctrl #(
    parameter int unsigned TAG_W      = 18,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned OFF_W      = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LOOKUP_LAT = 1,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    // cache port
    output logic [TAG_W-1:0]  c_tag,
    output logic [IDX_W-1:0]  c_index,
    output logic [OFF_W-1:0]  c_offset,
    output logic [DATA_W-1:0] c_dataW,
    output logic              c_memRW,
    output logic [DATA_W-1:0] c_mem_line,
    output logic              c_mem_resp,
    input  logic [DATA_W-1:0] c_data,
    input  logic              c_miss,
    input  logic              c_evict,
    input  logic [DATA_W-1:0] c_evict_data,
    input  logic [31:0]       c_evict_addr,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // statistics
    output logic [15:0]       miss_cnt
);

    localparam int unsigned LAT_W = $clog2(LOOKUP_LAT + 1);
    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWb,
        StFill,
        StResp,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              replay_q, replay_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_line_q, mem_line_d;
    logic [DATA_W-1:0] evict_data_q, evict_data_d;
    logic [31:0]       evict_addr_q, evict_addr_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic lookup_due;
    logic timer_exp;

    // Cache outputs are trusted only once the inputs have been stable LOOKUP_LAT cycles.
    assign lookup_due = (lat_cnt_q == LAT_W'(LOOKUP_LAT));
    // Expiring one short of TIMEOUT bounds mem_req to TIMEOUT-1 cycles per transfer.
    assign timer_exp  = (timer_q == TMR_W'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            index_q      <= '0;
            offset_q     <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            replay_q     <= 1'b0;
            lat_cnt_q    <= '0;
            timer_q      <= '0;
            rdata_q      <= '0;
            mem_line_q   <= '0;
            evict_data_q <= '0;
            evict_addr_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            offset_q     <= offset_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            replay_q     <= replay_d;
            lat_cnt_q    <= lat_cnt_d;
            timer_q      <= timer_d;
            rdata_q      <= rdata_d;
            mem_line_q   <= mem_line_d;
            evict_data_q <= evict_data_d;
            evict_addr_q <= evict_addr_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        offset_d     = offset_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        replay_d     = replay_q;
        lat_cnt_d    = lat_cnt_q;
        timer_d      = timer_q;
        rdata_d      = rdata_q;
        mem_line_d   = mem_line_q;
        evict_data_d = evict_data_q;
        evict_addr_d = evict_addr_q;
        miss_cnt_d   = miss_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    offset_d  = cpu_addr[OFF_W-1:0];
                    index_d   = cpu_addr[OFF_W +: IDX_W];
                    tag_d     = cpu_addr[OFF_W+IDX_W +: TAG_W];
                    we_d      = cpu_we;
                    wdata_d   = cpu_wdata;
                    replay_d  = 1'b0;
                    lat_cnt_d = '0;
                    state_d   = StLookup;
                end
            end
            StLookup: begin
                if (lookup_due) begin
                    lat_cnt_d = '0;
                    if (!c_miss) begin
                        rdata_d = we_q ? '0 : c_data;
                        state_d = StDone;
                    end else if (replay_q) begin
                        // The line just returned is still missing: give up.
                        rdata_d = '0;
                        state_d = StErr;
                    end else begin
                        miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                        timer_d    = '0;
                        if (c_evict) begin
                            evict_addr_d = c_evict_addr;
                            evict_data_d = c_evict_data;
                            state_d      = StWb;
                        end else begin
                            state_d = StFill;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            StWb: begin
                if (mem_ack) begin
                    timer_d = '0;
                    state_d = StFill;
                end else if (timer_exp) begin
                    rdata_d = '0;
                    state_d = StErr;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StFill: begin
                if (mem_ack) begin
                    mem_line_d = mem_rdata;
                    state_d    = StResp;
                end else if (timer_exp) begin
                    rdata_d = '0;
                    state_d = StErr;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StResp: begin
                replay_d  = 1'b1;
                lat_cnt_d = '0;
                state_d   = StLookup;
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from state so that reset removes them asynchronously.
    always_comb begin
        cpu_ready = (state_q == StIdle);
        cpu_done  = (state_q == StDone) || (state_q == StErr);
        cpu_err   = (state_q == StErr);
        mem_req   = (state_q == StWb) || (state_q == StFill);
        mem_we    = (state_q == StWb);
        mem_addr  = 32'({tag_q, index_q, {OFF_W{1'b0}}});
        mem_wdata = '0;
        if (state_q == StWb) begin
            mem_addr  = evict_addr_q;
            mem_wdata = evict_data_q;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign c_tag      = tag_q;
    assign c_index    = index_q;
    assign c_offset   = offset_q;
    assign c_dataW    = wdata_q;
    assign c_memRW    = we_q;
    assign c_mem_line = mem_line_q;
    assign c_mem_resp = (state_q == StResp);
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Bench for sa_cache_miss_ctrl: behavioural cache and memory responders, and a per-request
// reference prediction of result, error, memory transfers and miss count.
`timescale 1ns / 1ps

module tb_sa_cache_miss_ctrl;

    localparam int TAG_W      = 18;
    localparam int IDX_W      = 8;
    localparam int OFF_W      = 6;
    localparam int DATA_W     = 32;
    localparam int LOOKUP_LAT = 1;
    localparam int TIMEOUT    = 8;
    localparam int KEY_W      = TAG_W + IDX_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ready, cpu_done, cpu_err;
    logic [DATA_W-1:0] cpu_rdata;
    logic [TAG_W-1:0]  c_tag;
    logic [IDX_W-1:0]  c_index;
    logic [OFF_W-1:0]  c_offset;
    logic [DATA_W-1:0] c_dataW, c_mem_line, c_data, c_evict_data;
    logic              c_memRW, c_mem_resp, c_miss, c_evict;
    logic [31:0]       c_evict_addr;
    logic              mem_req, mem_we, mem_ack;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [15:0]       miss_cnt;

    sa_cache_miss_ctrl #(
        .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .DATA_W(DATA_W),
        .LOOKUP_LAT(LOOKUP_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .c_tag(c_tag), .c_index(c_index), .c_offset(c_offset), .c_dataW(c_dataW),
        .c_memRW(c_memRW), .c_mem_line(c_mem_line), .c_mem_resp(c_mem_resp),
        .c_data(c_data), .c_miss(c_miss), .c_evict(c_evict), .c_evict_data(c_evict_data),
        .c_evict_addr(c_evict_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .miss_cnt(miss_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cache environment: resident lines by {tag,index}, registered one-cycle lookup.
    logic [DATA_W-1:0] lines [logic [KEY_W-1:0]];
    logic [KEY_W-1:0]  env_key;
    logic              env_evict = 1'b0, env_drop_fill = 1'b0;
    logic [31:0]       env_evict_addr = '0;
    logic [DATA_W-1:0] env_evict_data = '0;
    assign env_key = {c_tag, c_index};

    always @(posedge clk) begin
        if (c_mem_resp && !env_drop_fill) lines[env_key] = c_mem_line;
        c_miss       <= !lines.exists(env_key);
        c_data       <= lines.exists(env_key) ? lines[env_key] : '0;
        c_evict      <= !lines.exists(env_key) && env_evict;
        c_evict_addr <= env_evict_addr;
        c_evict_data <= env_evict_data;
    end

    // Memory environment: acks each transfer mem_delay cycles after first seeing mem_req.
    int                mem_delay = 0;
    int                mem_wait = 0;
    logic              mem_never = 1'b0;
    logic [DATA_W-1:0] mem_fill_data = '0;
    assign mem_rdata = mem_fill_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack  <= 1'b0;
            mem_wait <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_req && !mem_ack) begin
                if (!mem_never && mem_wait == mem_delay) begin
                    mem_ack  <= 1'b1;
                    mem_wait <= 0;
                end else begin
                    mem_wait <= mem_wait + 1;
                end
            end else begin
                mem_wait <= 0;
            end
        end
    end

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [DATA_W-1:0] data;
    } xfer_t;

    xfer_t got_q[$];
    int    resp_cnt = 0;
    int    req_cycles = 0;

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) got_q.push_back(xfer_t'({mem_we, mem_addr, mem_wdata}));
        if (rst_n && c_mem_resp) resp_cnt++;
        if (rst_n && mem_req) req_cycles++;
    end

    logic [15:0] model_cnt = '0;

    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic evict,
                           input logic [31:0] ev_addr, input logic [DATA_W-1:0] ev_data,
                           input int delay, input logic never, input logic drop,
                           input logic [DATA_W-1:0] fill, input logic poke);
        logic [KEY_W-1:0]  key;
        logic              hit, exp_err, ack_ok, xfer_ok;
        logic [DATA_W-1:0] exp_rdata;
        logic [31:0]       line_addr, r;
        xfer_t             exp_q[$];
        int                exp_resp, exp_req, n;

        key       = addr[31:OFF_W];
        line_addr = {addr[31:OFF_W], {OFF_W{1'b0}}};
        hit       = lines.exists(key);
        exp_err   = 1'b0;
        exp_rdata = '0;
        exp_resp  = 0;
        exp_req   = 0;
        if (hit) begin
            exp_rdata = we ? '0 : lines[key];
        end else begin
            if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            // Ack seen on cycle delay+1 of the transfer; the limit is cycle TIMEOUT-2.
            ack_ok  = !never && (delay + 2 <= TIMEOUT - 1);
            xfer_ok = 1'b1;
            if (evict) begin
                if (ack_ok) begin
                    exp_q.push_back(xfer_t'({1'b1, ev_addr, ev_data}));
                    exp_req += delay + 2;
                end else begin
                    exp_req += TIMEOUT - 1;
                    xfer_ok = 1'b0;
                end
            end
            if (!xfer_ok) begin
                exp_err = 1'b1;
            end else if (ack_ok) begin
                exp_q.push_back(xfer_t'({1'b0, line_addr, {DATA_W{1'b0}}}));
                exp_req += delay + 2;
                exp_resp = 1;
                if (drop) exp_err = 1'b1;
                else exp_rdata = we ? '0 : fill;
            end else begin
                exp_req += TIMEOUT - 1;
                exp_err = 1'b1;
            end
        end

        env_evict      = evict;
        env_evict_addr = ev_addr;
        env_evict_data = ev_data;
        env_drop_fill  = drop;
        mem_delay      = delay;
        mem_never      = never;
        mem_fill_data  = fill;
        got_q.delete();
        resp_cnt   = 0;
        req_cycles = 0;

        check({tag, "_ready_before"}, cpu_ready, 1'b1);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(negedge clk);
        n = 1;
        r = $urandom;
        cpu_req  = poke;
        cpu_addr = r;
        cpu_we   = ~we;
        @(negedge clk);
        n = 2;
        cpu_req = 1'b0;
        while (!cpu_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, cpu_done, 1'b1);
        check({tag, "_err"}, cpu_err, exp_err);
        check({tag, "_rdata"}, cpu_rdata, exp_rdata);
        if (hit) check({tag, "_hit_latency"}, n, LOOKUP_LAT + 2);
        @(negedge clk);
        check({tag, "_done_pulse"}, cpu_done, 1'b0);
        check({tag, "_ready_after"}, cpu_ready, 1'b1);
        check({tag, "_miss_cnt"}, miss_cnt, model_cnt);
        check({tag, "_resp_pulses"}, resp_cnt, exp_resp);
        check({tag, "_req_cycles"}, req_cycles, exp_req);
        check({tag, "_xfer_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_xfer_we"}, got_q[i].we, exp_q[i].we);
            check({tag, "_xfer_addr"}, got_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check({tag, "_xfer_wdata"}, got_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        int          n;

        // Reset state, checked while rst_n is still low.
        #12;
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_done", cpu_done, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_miss_cnt", miss_cnt, 16'h0000);
        check("rst_rdata", cpu_rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        lines[26'(32'h0000_1040 >> OFF_W)] = 32'h1234_5678;
        run_req("hit", 1'b0, 32'h0000_1040, '0, 1'b0, '0, '0, 0, 1'b0, 1'b0, '0, 1'b0);
        run_req("clean_miss", 1'b0, 32'h0004_0080, '0, 1'b0, '0, '0, 2, 1'b0, 1'b0,
                32'hCAFE_F00D, 1'b0);
        run_req("dirty_miss", 1'b1, 32'h0010_0104, 32'h5555_AAAA, 1'b1, 32'h0008_0080,
                32'hDEAD_BEEF, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
        run_req("timeout", 1'b0, 32'h0020_0000, '0, 1'b0, '0, '0, 0, 1'b1, 1'b0, '0, 1'b0);
        run_req("ack_last", 1'b0, 32'h0030_0040, '0, 1'b0, '0, '0, 5, 1'b0, 1'b0,
                32'h7777_0001, 1'b0);
        run_req("ack_late", 1'b0, 32'h0031_0040, '0, 1'b0, '0, '0, 6, 1'b0, 1'b0,
                32'h7777_0002, 1'b0);
        run_req("wb_timeout", 1'b1, 32'h0032_0000, 32'h1, 1'b1, 32'h0009_0000, 32'h2, 0,
                1'b1, 1'b0, '0, 1'b0);
        run_req("replay_miss", 1'b0, 32'h0033_0000, '0, 1'b0, '0, '0, 0, 1'b0, 1'b1,
                32'h3, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            run_req("rand", ra[0], {16'h0040, 6'(ra[5:2]), 4'(ra[9:6]), ra[15:10]}, rb,
                    ra[16], {rc[31:OFF_W], {OFF_W{1'b0}}}, $urandom,
                    int'($urandom_range(0, 6)), 1'b0, ($urandom_range(0, 7) == 0), $urandom,
                    ra[17]);
        end

        // Saturation: preset the counter near its ceiling and keep missing.
        force dut.miss_cnt_q = 16'hFFFD;
        #1 release dut.miss_cnt_q;
        model_cnt = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            run_req("sat", 1'b0, {8'h7F, 4'(k), ra[19:0]}, '0, 1'b0, '0, '0, 0, 1'b0, 1'b0,
                    ra, 1'b0);
        end
        check("sat_final", miss_cnt, 16'hFFFF);

        // Reset while the fill is outstanding.
        env_evict     = 1'b0;
        env_drop_fill = 1'b0;
        mem_never     = 1'b1;
        cpu_req       = 1'b1;
        cpu_we        = 1'b0;
        cpu_addr      = 32'h0050_0000;
        @(negedge clk);
        cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_fill_reached", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_fill_mem_req", mem_req, 1'b0);
        check("rst_fill_ready", cpu_ready, 1'b1);
        check("rst_fill_miss_cnt", miss_cnt, 16'h0000);
        check("rst_fill_done", cpu_done, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_never = 1'b0;
        model_cnt = '0;
        @(negedge clk);
        run_req("post_rst_hit", 1'b0, 32'h0000_1040, '0, 1'b0, '0, '0, 0, 1'b0, 1'b0, '0,
                1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
